vector_swizzle_unit: RTL

Parametrised lane selector for the fixed-point vector datapath, the next generation of the single-lane vector select. Supports two modes:
- Vector mode: arbitrary per-lane swizzle (e.g. .wzyx, .xxxx), registered, with valid/ready handshakes.
- Scalar-stream mode: emits a programmable sequence of selected lanes one per cycle, serialising a vector into a scalar stream.

Sits between register-file read and the scalar/vector ALUs.

---
 rtl/vector_swizzle_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vector_swizzle_unit.sv
// Vector lane swizzle / scalar-stream serialiser with valid/ready handshakes.
// Optional saturating per-slot negate is enabled by VECTOR_SWIZZLE_NEGATE_EN.
module vector_swizzle_unit #(
    parameter  int LANES = 4,
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(LANES)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*WIDTH-1:0] i_vector,
    input  logic [LANES*IDX_W-1:0] i_swizzle,
    input  logic                   i_mode,
    input  logic [IDX_W:0]         i_count,
`ifdef VECTOR_SWIZZLE_NEGATE_EN
    input  logic [LANES-1:0]       i_negate,
`endif
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*WIDTH-1:0] o_vector,
    output logic [WIDTH-1:0]       o_scalar,
    output logic                   o_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEC,
        S_STREAM
    } state_t;

    localparam logic [IDX_W:0] LANES_N = (IDX_W+1)'(LANES);
    localparam logic [IDX_W:0] ONE_N   = (IDX_W+1)'(1);

    state_t                 r_state;
    logic                   r_valid;
    logic                   r_last;
    logic [LANES*WIDTH-1:0] r_vector;
    logic [WIDTH-1:0]       r_scalar;
    logic [IDX_W-1:0]       r_slot;
    logic [IDX_W:0]         r_cnt;

    logic [WIDTH-1:0]       w_lane [LANES];
    logic [WIDTH-1:0]       w_sel  [LANES];
    logic [WIDTH-1:0]       w_out  [LANES];
    logic [LANES*WIDTH-1:0] w_swz;
    logic [IDX_W:0]         w_cnt;
    logic [IDX_W:0]         w_slot_nx;
    logic                   w_next_last;
    logic                   w_acc;
    logic                   w_cons;

`ifdef VECTOR_SWIZZLE_NEGATE_EN
    // Two's complement negate; the most negative value saturates to max positive.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        if (v == {1'b1, {(WIDTH-1){1'b0}}})
            return {1'b0, {(WIDTH-1){1'b1}}};
        return -v;
    endfunction
`endif

    // Unpack the source and the held output, and build the swizzled request.
    always_comb begin
        w_swz = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane[k] = i_vector[k*WIDTH +: WIDTH];
            w_out[k]  = r_vector[k*WIDTH +: WIDTH];
        end
        for (int k = 0; k < LANES; k++) begin
            w_sel[k] = w_lane[i_swizzle[k*IDX_W +: IDX_W]];
`ifdef VECTOR_SWIZZLE_NEGATE_EN
            if (i_negate[k])
                w_sel[k] = f_neg(w_sel[k]);
`endif
            w_swz[k*WIDTH +: WIDTH] = w_sel[k];
        end
    end

    // Effective beat count: 0 and anything above LANES mean a full vector.
    always_comb begin
        w_cnt = i_count;
        if (i_count == '0 || i_count > LANES_N)
            w_cnt = LANES_N;
    end

    // A new request may enter when idle or when the final beat is leaving.
    always_comb begin
        o_ready = 1'b0;
        unique case (r_state)
            S_IDLE:   o_ready = 1'b1;
            S_VEC:    o_ready = i_ready;
            S_STREAM: o_ready = i_ready && r_last;
            default:  o_ready = 1'b0;
        endcase
    end

    assign w_acc       = i_valid && o_ready;
    assign w_cons      = r_valid && i_ready;
    assign w_slot_nx   = {1'b0, r_slot} + ONE_N;
    assign w_next_last = (w_slot_nx == r_cnt - ONE_N);

    // Control FSM with registered outputs; stream beats index the held vector.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_vector <= '0;
            r_scalar <= '0;
            r_slot   <= '0;
            r_cnt    <= '0;
        end else if (w_acc) begin
            r_vector <= w_swz;
            r_scalar <= w_sel[0];
            r_valid  <= 1'b1;
            r_slot   <= '0;
            if (i_mode) begin
                r_state <= S_STREAM;
                r_cnt   <= w_cnt;
                r_last  <= (w_cnt == ONE_N);
            end else begin
                r_state <= S_VEC;
                r_cnt   <= ONE_N;
                r_last  <= 1'b1;
            end
        end else if (w_cons) begin
            if (r_state == S_STREAM && !r_last) begin
                r_slot   <= w_slot_nx[IDX_W-1:0];
                r_scalar <= w_out[w_slot_nx[IDX_W-1:0]];
                r_last   <= w_next_last;
            end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_vector = r_vector;
    assign o_scalar = r_scalar;
    assign o_last   = r_last;

endmodule
